// File: rtl/dsi_lane_dac_seq.sv
// Per-lane DAC code sequencer: shared 32-entry code/valid table, registered target
// stage and an output stage with optional per-lane slew limiting.
module dsi_lane_dac_seq #(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DAC_W     = 8,
  parameter int unsigned SLEW_STEP = 0,
  parameter int unsigned DAC_RST   = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [LANES-1:0]         lane_type,
  input  logic [2*LANES-1:0]       lane_state,
  input  logic [2*LANES-1:0]       lane_sym,
  input  logic                     cfg_we,
  input  logic [4:0]               cfg_addr,
  input  logic [DAC_W-1:0]         cfg_wdata,
  input  logic                     cfg_valid,
  output logic [LANES*DAC_W-1:0]   dac_o,
  output logic [LANES-1:0]         busy_o
);

  localparam int unsigned ENTRIES = 32;
  localparam logic [DAC_W-1:0] RST_CODE = DAC_W'(DAC_RST);
  localparam logic [DAC_W:0]   STEP_W   = (DAC_W+1)'(SLEW_STEP);

  // Index layout {type, state[1:0], sym[1:0]}: N line entries 0..15, P line 16..31.
  function automatic logic [7:0] dflt_code(input logic [4:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case (idx[4:2])
      3'b000: case (idx[1:0])
                2'd0: c = 8'h1A;
                2'd1: c = 8'h17;
                2'd2: c = 8'h15;
                default: c = 8'h11;
              endcase
      3'b001: c = 8'h27;
      3'b010: case (idx[1:0])
                2'd1: c = 8'h2E;
                2'd2: c = 8'h24;
                2'd3: c = 8'hFF;
                default: c = 8'h00;
              endcase
      3'b011: c = 8'h25;
      3'b100: case (idx[1:0])
                2'd0: c = 8'h27;
                2'd1: c = 8'h28;
                2'd2: c = 8'h2A;
                default: c = 8'h2D;
              endcase
      3'b110: case (idx[1:0])
                2'd2: c = 8'h1A;
                2'd3: c = 8'hC9;
                default: c = 8'h00;
              endcase
      default: c = 8'h1A;
    endcase
    return c;
  endfunction

  function automatic logic dflt_vld(input logic [4:0] idx);
    return !(idx[3:2] == 2'd2 && idx[1:0] == 2'd0);
  endfunction

  logic [DAC_W-1:0] tbl_code [ENTRIES];
  logic [ENTRIES-1:0] tbl_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tbl_code[i] <= DAC_W'(dflt_code(5'(i))) << (DAC_W - 8);
        tbl_vld[i]  <= dflt_vld(5'(i));
      end
    end else if (cfg_we) begin
      tbl_code[cfg_addr] <= cfg_wdata;
      tbl_vld[cfg_addr]  <= cfg_valid;
    end
  end

  logic [DAC_W-1:0] tgt_q [LANES];
  logic [DAC_W-1:0] tgt_d [LANES];
  logic [DAC_W-1:0] dac_q [LANES];
  logic [DAC_W-1:0] dac_d [LANES];
  logic [LANES-1:0] busy_q, busy_d;

  logic [4:0]              idx;
  logic signed [DAC_W:0]   diff;
  logic [DAC_W:0]          mag;

  always_comb begin
    idx    = '0;
    diff   = '0;
    mag    = '0;
    busy_d = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      idx = {lane_type[l], lane_state[2*l +: 2], lane_sym[2*l +: 2]};
      tgt_d[l] = tgt_q[l];
      if (en && tbl_vld[idx])
        tgt_d[l] = tbl_code[idx];

      // Stage 2 tracks the registered target, so retargeting mid-ramp continues from dac_q.
      diff = $signed({1'b0, tgt_q[l]}) - $signed({1'b0, dac_q[l]});
      mag  = diff[DAC_W] ? $unsigned(-diff) : $unsigned(diff);
      if (SLEW_STEP == 0 || mag <= STEP_W)
        dac_d[l] = tgt_q[l];
      else if (diff[DAC_W])
        dac_d[l] = dac_q[l] - STEP_W[DAC_W-1:0];
      else
        dac_d[l] = dac_q[l] + STEP_W[DAC_W-1:0];

      busy_d[l] = (dac_d[l] != tgt_d[l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        tgt_q[l] <= RST_CODE;
        dac_q[l] <= RST_CODE;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned l = 0; l < LANES; l++) begin
        tgt_q[l] <= tgt_d[l];
        dac_q[l] <= dac_d[l];
      end
      busy_q <= busy_d;
    end
  end

  always_comb begin
    dac_o = '0;
    for (int unsigned l = 0; l < LANES; l++)
      dac_o[l*DAC_W +: DAC_W] = dac_q[l];
    busy_o = busy_q;
  end

endmodule

// File: tb/tb_dsi_lane_dac_seq.sv
// Bench for dsi_lane_dac_seq: an unlimited and a slew-limited (step 4) instance share
// stimulus and are compared every cycle against an integer reference model.
module tb_dsi_lane_dac_seq;

  logic        clk = 1'b0;
  logic        rst_n, en, cfg_we, cfg_valid;
  logic [1:0]  lane_type;
  logic [3:0]  lane_state, lane_sym;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [15:0] dac_a, dac_b;
  logic [1:0]  busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dsi_lane_dac_seq #(.LANES(2), .DAC_W(8), .SLEW_STEP(0), .DAC_RST(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .lane_type(lane_type), .lane_state(lane_state),
    .lane_sym(lane_sym), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_valid(cfg_valid), .dac_o(dac_a), .busy_o(busy_a));

  dsi_lane_dac_seq #(.LANES(2), .DAC_W(8), .SLEW_STEP(4), .DAC_RST(0)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .lane_type(lane_type), .lane_state(lane_state),
    .lane_sym(lane_sym), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_valid(cfg_valid), .dac_o(dac_b), .busy_o(busy_b));

  // Default table by index {type,state,sym}; -1 marks an invalid entry.
  int dflt [32] = '{
    'h1A, 'h17, 'h15, 'h11,  'h27, 'h27, 'h27, 'h27,
    -1,   'h2E, 'h24, 'hFF,  'h25, 'h25, 'h25, 'h25,
    'h27, 'h28, 'h2A, 'h2D,  'h1A, 'h1A, 'h1A, 'h1A,
    -1,   'h00, 'h1A, 'hC9,  'h1A, 'h1A, 'h1A, 'h1A};

  int m_tbl  [32];
  int m_tgt  [2][2];
  int m_dac  [2][2];
  int m_busy [2][2];
  int steps  [2] = '{0, 4};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_tbl[i] = dflt[i];
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 2; l++) begin
        m_tgt[d][l] = 0; m_dac[d][l] = 0; m_busy[d][l] = 0;
      end
  endfunction

  function automatic void model_clock();
    for (int d = 0; d < 2; d++)
      for (int l = 0; l < 2; l++) begin
        int ix, nt, nd, df, mg;
        ix = int'(lane_type[l]) * 16 + int'(lane_state[2*l +: 2]) * 4 + int'(lane_sym[2*l +: 2]);
        nt = (en && m_tbl[ix] >= 0) ? m_tbl[ix] : m_tgt[d][l];
        df = m_tgt[d][l] - m_dac[d][l];
        mg = (df < 0) ? -df : df;
        if (steps[d] == 0 || mg <= steps[d]) nd = m_tgt[d][l];
        else nd = m_dac[d][l] + ((df > 0) ? steps[d] : -steps[d]);
        m_tgt[d][l]  = nt;
        m_dac[d][l]  = nd;
        m_busy[d][l] = (nd != nt) ? 1 : 0;
      end
    if (cfg_we) m_tbl[cfg_addr] = cfg_valid ? int'(cfg_wdata) : -1;
  endfunction

  task automatic check_all();
    for (int l = 0; l < 2; l++) begin
      check($sformatf("a_dac%0d", l), 32'(dac_a[8*l +: 8]), 32'(m_dac[0][l]));
      check($sformatf("a_busy%0d", l), 32'(busy_a[l]), 32'(m_busy[0][l]));
      check($sformatf("b_dac%0d", l), 32'(dac_b[8*l +: 8]), 32'(m_dac[1][l]));
      check($sformatf("b_busy%0d", l), 32'(busy_b[l]), 32'(m_busy[1][l]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called from posedge+1, so the pulse sits well clear of both clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_dac_a", 32'(dac_a), 32'h0);
    check("rst_dac_b", 32'(dac_b), 32'h0);
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic set_lane(input int l, input bit t, input int st, input int sy);
    lane_type[l]        = t;
    lane_state[2*l +: 2] = 2'(st);
    lane_sym[2*l +: 2]   = 2'(sy);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_we = 1'b0; cfg_valid = 1'b0;
    lane_type = '0; lane_state = '0; lane_sym = '0; cfg_addr = '0; cfg_wdata = '0;
    model_reset();
    #12;
    check("reset_dac", 32'(dac_a), 32'h0);
    check("reset_busy", 32'(busy_a), 32'h0);
    check_all();
    rst_n = 1'b1;
    en    = 1'b1;

    // All inputs zero -> N st0 sym0 on both lanes after two clocks
    ticks(2);
    check("t1_dac", 32'(dac_a), 32'h1A1A);

    set_lane(0, 1'b1, 0, 3);
    ticks(2);
    check("t2_l0", 32'(dac_a[7:0]), 32'h2D);
    check("t2_l1", 32'(dac_a[15:8]), 32'h1A);

    set_lane(0, 1'b0, 0, 0);
    ticks(2);
    set_lane(0, 1'b1, 2, 0);
    ticks(6);
    check("t3_hold", 32'(dac_a[7:0]), 32'h1A);

    // Slew ramp up to 0x2D and back down to 0x00 on instance b
    pulse_reset();
    set_lane(0, 1'b1, 0, 3);
    set_lane(1, 1'b0, 0, 0);
    ticks(12);
    check("t4_up_busy", 32'(busy_b[0]), 32'h1);
    check("t4_up_2c", 32'(dac_b[7:0]), 32'h2C);
    tick();
    check("t4_up_end", 32'(dac_b[7:0]), 32'h2D);
    check("t4_up_idle", 32'(busy_b[0]), 32'h0);
    set_lane(0, 1'b1, 2, 1);
    ticks(12);
    check("t4_dn_busy", 32'(busy_b[0]), 32'h1);
    tick();
    check("t4_dn_end", 32'(dac_b[7:0]), 32'h00);

    // Reset in the middle of a ramp
    set_lane(0, 1'b1, 0, 3);
    ticks(7);
    check("t6_pre", 32'(dac_b[7:0]), 32'h18);
    pulse_reset();

    // Write to the entry being looked up in the same clock: old code first
    cfg_we = 1'b1; cfg_addr = 5'h13; cfg_wdata = 8'h40; cfg_valid = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    check("t5_old", 32'(dac_a[7:0]), 32'h2D);
    tick();
    check("t5_new", 32'(dac_a[7:0]), 32'h40);
    cfg_we = 1'b1; cfg_wdata = 8'h55; cfg_valid = 1'b0;
    tick();
    cfg_we = 1'b0;
    ticks(3);
    check("t5_inval", 32'(dac_a[7:0]), 32'h40);
    pulse_reset();
    ticks(2);
    check("t5_restored", 32'(dac_a[7:0]), 32'h2D);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      en         = ($urandom_range(0, 9) != 0);
      lane_type  = 2'($urandom);
      lane_state = 4'($urandom);
      lane_sym   = 4'($urandom);
      cfg_we     = ($urandom_range(0, 7) == 0);
      cfg_addr   = 5'($urandom);
      cfg_wdata  = 8'($urandom);
      cfg_valid  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) tick();
      else begin
        tick();
        lane_type = lane_type;
        cfg_we    = 1'b0;
        ticks($urandom_range(1, 6));
      end
      if ($urandom_range(0, 99) == 0) pulse_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
